// File: rtl/gift_inv_sbox_masked.sv
// Two-share masked GIFT inverse S-box with a two-stage valid/ready pipeline.
// S1 registers domain-separated degree-2 terms; S2 forms the cubic terms and compresses to the output shares.
module gift_inv_sbox_masked #(
    parameter int RAND_W     = 8,
    parameter bit CLEAR_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_s0,
    input  logic [3:0]        in_s1,
    input  logic [RAND_W-1:0] rand_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_s0,
    output logic [3:0]        out_s1
);

    // Quadratic monomials x_a*x_b and the fresh bit masking each cross-domain term.
    // Products with disjoint operands share a random bit.
    localparam int NP = 6;
    localparam int PA [NP] = '{0, 0, 1, 0, 1, 2};
    localparam int PB [NP] = '{1, 2, 2, 3, 3, 3};
    localparam int PR [NP] = '{0, 1, 2, 2, 1, 0};

    logic            s1_valid_reg;
    logic [3:0]      lin0_reg, lin1_reg;
    logic [NP-1:0]   inner0_reg, inner1_reg, cross01_reg, cross10_reg;
    logic [3:0]      rand_hi_reg;
    logic            s2_valid_reg;
    logic [3:0]      out0_reg, out1_reg;

    logic            s2_load, s1_load;
    logic [3:0]      lin0_next, lin1_next;
    logic [NP-1:0]   inner0_next, inner1_next, cross01_next, cross10_next;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    // Linear shares are re-randomised on x0; the sharing changes, the value does not.
    assign lin0_next = in_s0 ^ {3'b000, rand_in[3]};
    assign lin1_next = in_s1 ^ {3'b000, rand_in[3]};

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_dom_and
            assign inner0_next[gi]  = in_s0[PA[gi]] & in_s0[PB[gi]];
            assign inner1_next[gi]  = in_s1[PA[gi]] & in_s1[PB[gi]];
            assign cross01_next[gi] = (in_s0[PA[gi]] & in_s1[PB[gi]]) ^ rand_in[PR[gi]];
            assign cross10_next[gi] = (in_s1[PA[gi]] & in_s0[PB[gi]]) ^ rand_in[PR[gi]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            lin0_reg     <= '0;
            lin1_reg     <= '0;
            inner0_reg   <= '0;
            inner1_reg   <= '0;
            cross01_reg  <= '0;
            cross10_reg  <= '0;
            rand_hi_reg  <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                lin0_reg    <= lin0_next;
                lin1_reg    <= lin1_next;
                inner0_reg  <= inner0_next;
                inner1_reg  <= inner1_next;
                cross01_reg <= cross01_next;
                cross10_reg <= cross10_next;
                rand_hi_reg <= rand_in[7:4];
            end else if (CLEAR_IDLE) begin
                lin0_reg    <= '0;
                lin1_reg    <= '0;
                inner0_reg  <= '0;
                inner1_reg  <= '0;
                cross01_reg <= '0;
                cross10_reg <= '0;
                rand_hi_reg <= '0;
            end
        end
    end

    // ANF of the inverse S-box, evaluated on one share; cst injects the constant term into share 0 only.
    function automatic logic [3:0] inv_share(input logic [3:0] l, input logic [NP-1:0] q,
                                             input logic c012, input logic c013, input logic cst,
                                             input logic r6, input logic r7);
        logic [3:0] y;
        y[0] = cst ^ l[0] ^ l[1] ^ l[2] ^ l[3] ^ q[0] ^ q[1] ^ q[2] ^ c013;
        y[1] = l[2] ^ l[3] ^ q[0] ^ q[1] ^ q[2] ^ q[4] ^ q[5] ^ c012;
        y[2] = cst ^ l[0] ^ l[1] ^ l[2] ^ q[3] ^ r6;
        y[3] = cst ^ l[0] ^ l[2] ^ q[4] ^ r7;
        return y;
    endfunction

    logic [1:0][3:0]    lin_sh;
    logic [1:0][NP-1:0] q_sh;
    logic [1:0]         c012_sh, c013_sh;
    logic [1:0][3:0]    y_sh;

    assign lin_sh[0] = lin0_reg;
    assign lin_sh[1] = lin1_reg;
    assign q_sh[0]   = inner0_reg ^ cross01_reg;
    assign q_sh[1]   = inner1_reg ^ cross10_reg;

    // Cubic terms x0x1x2 and x0x1x3 as DOM products of the x0x1 share with x2 / x3.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_share
            assign c012_sh[gi] = (q_sh[gi][0] & lin_sh[gi][2])
                               ^ ((q_sh[gi][0] & lin_sh[1-gi][2]) ^ rand_hi_reg[0]);
            assign c013_sh[gi] = (q_sh[gi][0] & lin_sh[gi][3])
                               ^ ((q_sh[gi][0] & lin_sh[1-gi][3]) ^ rand_hi_reg[1]);
            assign y_sh[gi]    = inv_share(lin_sh[gi], q_sh[gi], c012_sh[gi], c013_sh[gi],
                                           1'(gi == 0), rand_hi_reg[2], rand_hi_reg[3]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            out0_reg     <= '0;
            out1_reg     <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out0_reg <= y_sh[0];
                out1_reg <= y_sh[1];
            end else if (CLEAR_IDLE) begin
                out0_reg <= '0;
                out1_reg <= '0;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_s0    = out0_reg;
    assign out_s1    = out1_reg;

endmodule

// File: tb/tb_gift_inv_sbox_masked.sv
// Randomised self-checking bench for gift_inv_sbox_masked against the inverse S-box table.
module tb_gift_inv_sbox_masked;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_s0 = '0;
    logic [3:0] in_s1 = '0;
    logic [7:0] rand_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_s0;
    logic [3:0] out_s1;

    gift_inv_sbox_masked #(.RAND_W(8), .CLEAR_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_s0(in_s0), .in_s1(in_s1), .rand_in(rand_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_s0(out_s0), .out_s1(out_s1)
    );

    always #5 clk = ~clk;

    logic [3:0] inv_tbl [16] = '{4'hd, 4'h0, 4'h8, 4'h6, 4'h2, 4'hc, 4'h4, 4'hb,
                                 4'he, 4'h7, 4'h1, 4'ha, 4'h3, 4'h9, 4'hf, 4'h5};

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor: records output transfers and stall-stability violations.
    int         cyc = 0;
    logic [3:0] got_q [$];
    logic [3:0] got_s0_q [$];
    int         got_cyc_q [$];
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_s0, prev_s1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cyc++;
            if (prev_stall && (!out_valid || out_s0 !== prev_s0 || out_s1 !== prev_s1))
                stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_s0 = out_s0;
            prev_s1 = out_s1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_s0 ^ out_s1);
                got_s0_q.push_back(out_s0);
                got_cyc_q.push_back(cyc);
            end
        end
    end

    logic [3:0] stim_s0 [1024];
    logic [3:0] stim_s1 [1024];
    logic [7:0] stim_r  [1024];
    int         stream_cycles;
    logic       hold_ready;

    task automatic clear_mon();
        got_q.delete();
        got_s0_q.delete();
        got_cyc_q.delete();
        stall_viol = 0;
    endtask

    // Drives n stimulus items; mode 1 randomises out_ready with a 5-cycle forced stall.
    task automatic drive_stream(input int n, input int mode);
        int idx = 0;
        int c = 0;
        logic acc;
        while (idx < n && c < 5000) begin
            in_valid = 1'b1;
            in_s0 = stim_s0[idx];
            in_s1 = stim_s1[idx];
            rand_in = stim_r[idx];
            if (mode == 0) out_ready = 1'b1;
            else if (c >= 6 && c < 11) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            if (mode == 1 && c == 10) hold_ready = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
        end
        stream_cycles = c;
        in_valid = 1'b0;
        for (int k = 0; k < 400 && got_q.size() < n; k++) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen = 0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_s0, out_s1, in_ready} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b s0=%h s1=%h rdy=%b, need v=0 s0=0 s1=0 rdy=1",
                     out_valid, out_s0, out_s1, in_ready);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_s0 = 4'h3; in_s1 = 4'hc; rand_in = 8'h5a; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_prefill: got v=%b rdy=%b, need v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_s0, out_s1, in_ready} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%b s0=%h s1=%h rdy=%b, need v=0 s0=0 s1=0 rdy=1",
                     out_valid, out_s0, out_s1, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_output: got %0d valid cycles after release, need 0", seen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single(input logic [3:0] s0, input logic [3:0] s1);
        logic [3:0] exp = inv_tbl[s0 ^ s1];
        in_valid = 1'b1; in_s0 = s0; in_s1 = s1; rand_in = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early x=%h: got out_valid=%b after 1 edge, need 0", s0 ^ s1, out_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || (out_s0 ^ out_s1) !== exp) begin
            tests_failed++;
            $display("FAIL single x=%h: got v=%b xor=%h, need v=1 xor=%h", s0 ^ s1, out_valid, out_s0 ^ out_s1, exp);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_once x=%h: got out_valid=%b, need 0", s0 ^ s1, out_valid);
        end
    endtask

    task automatic test_exhaustive();
        int gaps = 0;
        clear_mon();
        for (int i = 0; i < 1024; i++) begin
            stim_s0[i] = 4'($urandom);
            stim_s1[i] = stim_s0[i] ^ 4'(i / 64);
            stim_r[i]  = 8'($urandom);
        end
        drive_stream(1024, 0);
        tests_run++;
        if (got_q.size() !== 1024 || stream_cycles !== 1024) begin
            tests_failed++;
            $display("FAIL exhaustive_count: got %0d outputs in %0d input cycles, need 1024 in 1024",
                     got_q.size(), stream_cycles);
        end
        for (int i = 0; i < got_q.size() && i < 1024; i++) begin
            tests_run++;
            if (got_q[i] !== inv_tbl[i / 64]) begin
                tests_failed++;
                $display("FAIL exhaustive[%0d] x=%h: got %h, need %h", i, i / 64, got_q[i], inv_tbl[i / 64]);
            end
            if (i > 0 && got_cyc_q[i] - got_cyc_q[i-1] != 1) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL exhaustive_throughput: got %0d gaps in output stream, need 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        hold_ready = 1'bx;
        for (int i = 0; i < 16; i++) begin
            stim_s0[i] = 4'($urandom);
            stim_s1[i] = stim_s0[i] ^ 4'(i);
            stim_r[i]  = 8'($urandom);
        end
        drive_stream(16, 1);
        tests_run++;
        if (got_q.size() !== 16) begin
            tests_failed++;
            $display("FAIL backpressure_count: got %0d outputs, need 16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            tests_run++;
            if (got_q[i] !== inv_tbl[i]) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: got %h, need %h", i, got_q[i], inv_tbl[i]);
            end
        end
        tests_run++;
        if (stall_viol !== 0) begin
            tests_failed++;
            $display("FAIL backpressure_stable: got %0d stall violations, need 0", stall_viol);
        end
        tests_run++;
        if (hold_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_full: got in_ready=%b while full, need 0", hold_ready);
        end
    endtask

    task automatic test_randomness();
        int diff = 0;
        clear_mon();
        for (int i = 0; i < 256; i++) begin
            stim_s0[i] = 4'h0;
            stim_s1[i] = 4'h7;
            stim_r[i]  = 8'(i);
        end
        drive_stream(256, 0);
        tests_run++;
        if (got_q.size() !== 256) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d outputs, need 256", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== 4'hb) begin
                tests_failed++;
                $display("FAIL rand_xor r=%h: got %h, need b", i, got_q[i]);
            end
            if (got_s0_q[i] !== got_s0_q[0]) diff++;
        end
        tests_run++;
        if (diff == 0) begin
            tests_failed++;
            $display("FAIL rand_spread: got 1 distinct out_s0 value, need at least 2");
        end
    endtask

    task automatic test_bubbles();
        int outs = 0;
        logic [3:0] x;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            x = 4'($urandom);
            in_s0 = 4'($urandom);
            in_s1 = in_s0 ^ x;
            rand_in = 8'($urandom);
            in_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(negedge clk);
                tests_run++;
                if (out_valid) begin
                    outs++;
                    if ((out_s0 ^ out_s1) !== inv_tbl[x]) begin
                        tests_failed++;
                        $display("FAIL bubble_data x=%h: got %h, need %h", x, out_s0 ^ out_s1, inv_tbl[x]);
                    end
                end else if (out_s0 !== 4'h0 || out_s1 !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL bubble_clear: got s0=%h s1=%h on idle cycle, need 0 0", out_s0, out_s1);
                end
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (outs !== 6) begin
            tests_failed++;
            $display("FAIL bubble_count: got %0d outputs, need 6", outs);
        end
    endtask

    initial begin
        test_reset();
        test_single(4'h0, 4'h0);
        test_single(4'ha, 4'h5);
        test_exhaustive();
        test_backpressure();
        test_randomness();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
